// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer driving the shared W-bit ALU, one ALU op per cycle.
// Produces the low W bits of an unsigned product; stops as soon as the remaining multiplier is zero.
module alu_mul_seq #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPS = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   product,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPS-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_sign
);

  localparam logic [OPS-1:0] OP_ADD = OPS'(0);
  localparam logic [OPS-1:0] OP_SHR = OPS'(1);
  localparam logic [OPS-1:0] OP_SHL = OPS'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHL   = 3'd3,
    S_SHR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] acc, acc_n;
  logic [W-1:0] mcand, mcand_n;
  logic [W-1:0] mplier, mplier_n;
  logic [W-1:0] product_n;

  // State and datapath registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      product <= product_n;
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
    end
  end

  // Next-state logic and combinational ALU drive.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    product_n = product;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_ADD;

    case (state)
      S_IDLE: begin
        if (start) begin
          acc_n    = '0;
          mcand_n  = multiplicand;
          mplier_n = multiplier;
          state_n  = S_CHECK;
        end
      end

      // Pass mplier through the adder so the ALU flags report zero / LSB.
      S_CHECK: begin
        alu_a = mplier;
        if (alu_zero) begin
          product_n = acc;
          state_n   = S_DONE;
        end else if (alu_sign) begin
          state_n = S_ADD;
        end else begin
          state_n = S_SHL;
        end
      end

      S_ADD: begin
        alu_a   = acc;
        alu_b   = mcand;
        acc_n   = alu_out;
        state_n = S_SHL;
      end

      S_SHL: begin
        alu_a   = mcand;
        alu_b   = W'(1);
        alu_op  = OP_SHL;
        mcand_n = alu_out;
        state_n = S_SHR;
      end

      S_SHR: begin
        alu_a    = mplier;
        alu_b    = W'(1);
        alu_op   = OP_SHR;
        mplier_n = alu_out;
        state_n  = S_CHECK;
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU, vector table with a scoreboard queue,
// plus hand-written held-start, mid-run reset and reset-with-start sequences.
module tb_alu_mul_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned OPS = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [W-1:0]   product;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPS-1:0] alu_op;
  logic [W-1:0]   alu_out;
  logic           alu_zero;
  logic           alu_sign;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [7:0] mc;
    logic [7:0] mp;
    logic [7:0] prod;
    int         cyc;
  } vec_t;

  typedef struct {
    logic [7:0] prod;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] op_log [0:63];

  alu_mul_seq #(.W(W), .OPS(OPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_sign     (alu_sign)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour: add, shift right, shift left, xor.
  always_comb begin
    case (alu_op)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a >> alu_b;
      3'b010:  alu_out = alu_a << alu_b;
      3'b011:  alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);
  assign alu_sign = alu_out[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] mc, input logic [7:0] mp);
    exp_t e;
    int   k = 0;
    int   p = 0;
    logic [15:0] full;
    for (int i = 0; i < 8; i++) begin
      if (mp[i]) begin
        k = i + 1;
        p++;
      end
    end
    full   = 16'(mc) * 16'(mp);
    e.prod = full[7:0];
    e.cyc  = 3 * k + p + 2;
    return e;
  endfunction

  // Drive a one-cycle start; returns once the accepting edge has passed.
  task automatic launch(input logic [7:0] mc, input logic [7:0] mp, input exp_t e);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = mc;
    multiplier   = mp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
  endtask

  // Count cycles after acceptance until done, then score against the queue head.
  task automatic wait_done(input string name);
    bit   seen = 1'b0;
    int   cyc  = 0;
    exp_t e;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      cyc       = i;
      op_log[i] = alu_op;
      if (i == 1) chk({name, "_busy_rise"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
        chk({name, "_product"}, 32'(product), 32'(e.prod));
        chk({name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        @(negedge clk);
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    vec_t       vecs [8];
    logic [2:0] exp_ops [12];
    exp_t       e;
    int         nd;
    int         d1;
    int         d2;

    vecs[0] = '{mc: 8'h03, mp: 8'h05, prod: 8'h0F, cyc: 13};
    vecs[1] = '{mc: 8'hAB, mp: 8'h00, prod: 8'h00, cyc: 2};
    vecs[2] = '{mc: 8'hFF, mp: 8'hFF, prod: 8'h01, cyc: 34};
    vecs[3] = '{mc: 8'h03, mp: 8'h80, prod: 8'h80, cyc: 27};
    vecs[4] = '{mc: 8'h07, mp: 8'h06, prod: 8'h2A, cyc: 13};
    vecs[5] = '{mc: 8'h10, mp: 8'h11, prod: 8'h10, cyc: 19};
    vecs[6] = '{mc: 8'h01, mp: 8'h01, prod: 8'h01, cyc: 6};
    vecs[7] = '{mc: 8'h55, mp: 8'h0A, prod: 8'h52, cyc: 16};
    exp_ops = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b010,
                3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      e.prod = vecs[v].prod;
      e.cyc  = vecs[v].cyc;
      launch(vecs[v].mc, vecs[v].mp, e);
      wait_done($sformatf("vec%0d", v));
      if (v == 0) begin
        for (int i = 0; i < 12; i++)
          chk($sformatf("op_seq%0d", i + 1), 32'(op_log[i + 1]), 32'(exp_ops[i]));
      end
      if (v == 1) chk("zero_mplier_check_op", 32'(op_log[1]), 32'd0);
    end

    for (int r = 0; r < 6; r++) begin
      logic [7:0] mc;
      logic [7:0] mp;
      mc = 8'($urandom);
      mp = 8'($urandom);
      launch(mc, mp, model(mc, mp));
      wait_done($sformatf("rnd%0d", r));
    end

    // Start held through a full 3x5 run, then re-accepted once back in IDLE.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'h03;
    multiplier   = 8'h05;
    @(posedge clk);
    nd = 0;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 15) start = 1'b0;
      if (i == 14) chk("hold_idle_busy", 32'(busy), 32'd0);
      if (done) begin
        nd++;
        if (nd == 1) d1 = i;
        if (nd == 2) begin
          d2 = i;
          chk("hold_product2", 32'(product), 32'h0F);
        end
      end
    end
    chk("hold_done_count", 32'(nd), 32'd2);
    chk("hold_done1_cycle", 32'(d1), 32'd13);
    chk("hold_done2_cycle", 32'(d2), 32'd27);

    // Reset in cycle 6 of a 0xFF x 0xFF run.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    e.prod = 8'h0F;
    e.cyc  = 13;
    launch(8'h03, 8'h05, e);
    wait_done("after_rst");

    // Reset and start together in IDLE, then start alone.
    @(negedge clk);
    reset        = 1'b1;
    start        = 1'b1;
    multiplicand = 8'h03;
    multiplier   = 8'h05;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    e.prod = 8'h0F;
    e.cyc  = 13;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("start_after_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
